// File: rtl/button_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// button_conditioner_pkg
//   Shared definitions for the button conditioner:
//     - EDGE_MODE encodings (EDGE_RISE / EDGE_FALL / EDGE_BOTH)
//     - auto-repeat state encoding (used only when
//       BUTTON_CONDITIONER_AUTOREPEAT_EN is defined)
//     - counter-width helper functions
// -----------------------------------------------------------------------------
package button_conditioner_pkg;

  // Which debounced-level edges produce an event pulse.
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_BOTH = 2;

  // Auto-repeat tracker: idle until a press pulse, armed while held.
  typedef enum logic [0:0] {
    REP_IDLE  = 1'b0,
    REP_ARMED = 1'b1
  } rep_state_e;

  // Bits needed to hold values 0..max_count (never less than one bit).
  function automatic int cnt_width(input int max_count);
    int w;
    w = $clog2(max_count + 1);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_channel.sv
// -----------------------------------------------------------------------------
// button_channel
//   One channel of the button conditioner: synchroniser chain, debouncer,
//   registered edge-pulse generator and (when BUTTON_CONDITIONER_AUTOREPEAT_EN
//   is defined) the hold/auto-repeat pulse logic.
//
//   Ports:
//     clk    in   single clock, rising edge
//     rst    in   asynchronous reset, active-low
//     press  in   raw asynchronous button line, 1 = pressed
//     level  out  debounced level (registered)
//     pulse  out  one-cycle event pulse (registered)
//
//   Build option: BUTTON_CONDITIONER_AUTOREPEAT_EN adds HOLD_CYCLES and
//   REPEAT_CYCLES parameters and the repeat counter.
// -----------------------------------------------------------------------------
module button_channel
  import button_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int DB_CYCLES     = 16,
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
  parameter int HOLD_CYCLES   = 1000,
  parameter int REPEAT_CYCLES = 200,
`endif
  parameter int EDGE_MODE     = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic press,
  output logic level,
  output logic pulse
);

  localparam int DB_W = cnt_width(DB_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sync_s;
  logic [DB_W-1:0]        db_cnt_r;
  logic [DB_W-1:0]        db_cnt_nxt_s;
  logic                   level_r;
  logic                   level_nxt_s;
  logic                   accept_s;
  logic                   rise_s;
  logic                   fall_s;
  logic                   edge_hit_s;
  logic                   pulse_r;
  logic                   pulse_nxt_s;

  // Synchroniser shift chain; the oldest stage is the usable sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], press};
    end
  end

  assign sync_s = sync_r[SYNC_STAGES-1];

  // Debounce: a differing sample must persist DB_CYCLES cycles to be accepted.
  always_comb begin
    db_cnt_nxt_s = db_cnt_r;
    level_nxt_s  = level_r;
    accept_s     = 1'b0;
    if (sync_s == level_r) begin
      db_cnt_nxt_s = {DB_W{1'b0}};
    end else if (db_cnt_r == DB_LAST) begin
      level_nxt_s  = sync_s;
      db_cnt_nxt_s = {DB_W{1'b0}};
      accept_s     = 1'b1;
    end else begin
      db_cnt_nxt_s = db_cnt_r + DB_ONE;
    end
  end

  // A level change is accepted this cycle; its direction is the new sample.
  assign rise_s = accept_s & sync_s;
  assign fall_s = accept_s & ~sync_s;

  // Select which accepted edges generate an event pulse.
  always_comb begin
    edge_hit_s = 1'b0;
    case (EDGE_MODE)
      EDGE_RISE: edge_hit_s = rise_s;
      EDGE_FALL: edge_hit_s = fall_s;
      EDGE_BOTH: edge_hit_s = accept_s;
      default:   edge_hit_s = 1'b0;
    endcase
  end

`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
  localparam int REP_W = cnt_width(max_of(HOLD_CYCLES, REPEAT_CYCLES));
  localparam logic [REP_W-1:0] HOLD_LOAD   = REP_W'(HOLD_CYCLES - 1);
  localparam logic [REP_W-1:0] REPEAT_LOAD = REP_W'(REPEAT_CYCLES - 1);
  localparam logic [REP_W-1:0] REP_ONE     = REP_W'(1);
  localparam bit REP_ACTIVE = (EDGE_MODE == EDGE_RISE) || (EDGE_MODE == EDGE_BOTH);

  rep_state_e       rep_state_r;
  rep_state_e       rep_state_nxt_s;
  logic [REP_W-1:0] rep_cnt_r;
  logic [REP_W-1:0] rep_cnt_nxt_s;
  logic             rep_fire_s;

  // Repeat state and countdown registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rep_state_r <= REP_IDLE;
      rep_cnt_r   <= {REP_W{1'b0}};
    end else begin
      rep_state_r <= rep_state_nxt_s;
      rep_cnt_r   <= rep_cnt_nxt_s;
    end
  end

  // Countdown loaded by the press pulse; the release edge wins over a
  // concurrent expiry so no repeat ever lines up with or follows release.
  always_comb begin
    rep_state_nxt_s = rep_state_r;
    rep_cnt_nxt_s   = rep_cnt_r;
    rep_fire_s      = 1'b0;
    case (rep_state_r)
      REP_IDLE: begin
        if (REP_ACTIVE && rise_s) begin
          rep_state_nxt_s = REP_ARMED;
          rep_cnt_nxt_s   = HOLD_LOAD;
        end else begin
          rep_state_nxt_s = REP_IDLE;
        end
      end
      REP_ARMED: begin
        if (fall_s || !level_r) begin
          rep_state_nxt_s = REP_IDLE;
          rep_cnt_nxt_s   = {REP_W{1'b0}};
        end else if (rep_cnt_r == {REP_W{1'b0}}) begin
          rep_fire_s    = 1'b1;
          rep_cnt_nxt_s = REPEAT_LOAD;
        end else begin
          rep_cnt_nxt_s = rep_cnt_r - REP_ONE;
        end
      end
      default: begin
        rep_state_nxt_s = REP_IDLE;
        rep_cnt_nxt_s   = {REP_W{1'b0}};
      end
    endcase
  end

  assign pulse_nxt_s = edge_hit_s | rep_fire_s;
`else
  assign pulse_nxt_s = edge_hit_s;
`endif

  // Debounced level, counter and registered pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_cnt_r <= {DB_W{1'b0}};
      level_r  <= 1'b0;
      pulse_r  <= 1'b0;
    end else begin
      db_cnt_r <= db_cnt_nxt_s;
      level_r  <= level_nxt_s;
      pulse_r  <= pulse_nxt_s;
    end
  end

  assign level = level_r;
  assign pulse = pulse_r;

endmodule

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//   Multi-channel push-button conditioner: CH independent channels, each
//   synchronised, debounced and turned into one-cycle event pulses.
//
//   Ports:
//     clk          in   single clock, rising edge
//     rst          in   asynchronous reset, active-low
//     press_i      in   [CH] raw button lines, 1 = pressed
//     level_o      out  [CH] debounced levels
//     pulse_o      out  [CH] one-cycle event pulses
//     any_pulse_o  out  OR of pulse_o
//
//   Build option: BUTTON_CONDITIONER_AUTOREPEAT_EN enables per-channel
//   auto-repeat (HOLD_CYCLES / REPEAT_CYCLES); otherwise those are ignored.
// -----------------------------------------------------------------------------
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int CH            = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int DB_CYCLES     = 16,
  parameter int EDGE_MODE     = 0,
  parameter int HOLD_CYCLES   = 1000,
  parameter int REPEAT_CYCLES = 200
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] press_i,
  output logic [CH-1:0] level_o,
  output logic [CH-1:0] pulse_o,
  output logic          any_pulse_o
);

  // Reject parameter sets the channel logic cannot implement.
  if (CH < 1 || SYNC_STAGES < 2 || DB_CYCLES < 1 || HOLD_CYCLES < 1 ||
      REPEAT_CYCLES < 1 || EDGE_MODE < EDGE_RISE || EDGE_MODE > EDGE_BOTH) begin : g_cfg_check
    $error("button_conditioner: illegal parameter set");
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    button_channel #(
      .SYNC_STAGES   (SYNC_STAGES),
      .DB_CYCLES     (DB_CYCLES),
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
      .HOLD_CYCLES   (HOLD_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES),
`endif
      .EDGE_MODE     (EDGE_MODE)
    ) u_channel (
      .clk   (clk),
      .rst   (rst),
      .press (press_i[i]),
      .level (level_o[i]),
      .pulse (pulse_o[i])
    );
  end

  // Combinational OR of registered pulses: no added latency.
  assign any_pulse_o = |pulse_o;

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
//   Table-driven bench for button_conditioner (CH=4, SYNC_STAGES=2,
//   DB_CYCLES=4, EDGE_MODE=0, HOLD_CYCLES=20, REPEAT_CYCLES=5) plus a
//   one-channel EDGE_MODE=2 instance, with hand-written reset sequences.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

  logic       clk;
  logic       rst;
  logic [3:0] press_i;
  logic [3:0] level_o;
  logic [3:0] pulse_o;
  logic       any_pulse_o;
  logic [0:0] press_b;
  logic [0:0] level_b;
  logic [0:0] pulse_b;
  logic       any_b;

  int n_vec;
  int n_err;

`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  button_conditioner #(
    .CH(4), .SYNC_STAGES(2), .DB_CYCLES(4), .EDGE_MODE(0),
    .HOLD_CYCLES(20), .REPEAT_CYCLES(5)
  ) u_dut (
    .clk(clk), .rst(rst), .press_i(press_i),
    .level_o(level_o), .pulse_o(pulse_o), .any_pulse_o(any_pulse_o)
  );

  button_conditioner #(
    .CH(1), .SYNC_STAGES(2), .DB_CYCLES(4), .EDGE_MODE(2),
    .HOLD_CYCLES(20), .REPEAT_CYCLES(5)
  ) u_both (
    .clk(clk), .rst(rst), .press_i(press_b),
    .level_o(level_b), .pulse_o(pulse_b), .any_pulse_o(any_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [3:0] press;
    logic       pb;
    logic [3:0] lvl;
    logic [3:0] pls;
    logic       lb;
    logic       plb;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [3:0] p, input logic pbv, input logic [3:0] l,
                     input logic [3:0] q, input logic lbv, input logic plbv);
    vec_t v;
    v.press = p; v.pb = pbv; v.lvl = l; v.pls = q; v.lb = lbv; v.plb = plbv;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] observed();
    return {level_o, pulse_o, any_pulse_o, level_b[0], pulse_b[0], any_b};
  endfunction

  initial begin
    logic [11:0] exp;
    n_vec = 0;
    n_err = 0;
    rst = 1'b0;
    press_i = 4'b0000;
    press_b = 1'b0;

    // Clean press on ch0 (12 cycles) alongside a both-edges press (10 cycles).
    for (int k = 0; k < 22; k++)
      add((k < 12) ? 4'b0001 : 4'b0000, (k < 10),
          (k >= 5 && k < 17) ? 4'b0001 : 4'b0000, (k == 5) ? 4'b0001 : 4'b0000,
          (k >= 5 && k < 15), (k == 5 || k == 15));
    // Bounce on ch1: H H H L H H L then H x10, then release.
    for (int k = 0; k < 25; k++)
      add((k < 3 || k == 4 || k == 5 || (k >= 7 && k < 17)) ? 4'b0010 : 4'b0000, 1'b0,
          (k >= 12 && k < 22) ? 4'b0010 : 4'b0000, (k == 12) ? 4'b0010 : 4'b0000,
          1'b0, 1'b0);
    // Glitch of 3 cycles on ch2 must be rejected.
    for (int k = 0; k < 12; k++)
      add((k < 3) ? 4'b0100 : 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
    // Simultaneous press on ch0 and ch3.
    for (int k = 0; k < 16; k++)
      add((k < 8) ? 4'b1001 : 4'b0000, 1'b0,
          (k >= 5 && k < 13) ? 4'b1001 : 4'b0000, (k == 5) ? 4'b1001 : 4'b0000,
          1'b0, 1'b0);
    // Long hold on ch0: level high from P=5 through P+37, repeats at P+20..P+35.
    for (int k = 0; k < 48; k++)
      add((k < 38) ? 4'b0001 : 4'b0000, 1'b0,
          (k >= 5 && k < 43) ? 4'b0001 : 4'b0000,
          (k == 5 || (AR && (k == 25 || k == 30 || k == 35 || k == 40))) ? 4'b0001 : 4'b0000,
          1'b0, 1'b0);

    // Reset state.
    #2;
    check("reset_state", observed(), 12'h000);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Table: apply at negedge, compare just after the sampling edge.
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      press_i = tbl[i].press;
      press_b = tbl[i].pb;
      @(posedge clk);
      #1;
      exp = {tbl[i].lvl, tbl[i].pls, |tbl[i].pls, tbl[i].lb, tbl[i].plb, tbl[i].plb};
      check($sformatf("vec%0d", i), observed(), exp);
    end

    // Reset mid-count: ch0 debounced high, ch1 partway through its count.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      press_i = 4'b0001;
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      press_i = 4'b0011;
    end
    @(posedge clk);
    #1;
    check("pre_reset_level", {8'h00, level_o}, 12'h001);
    #1;
    rst = 1'b0;
    #1;
    check("async_reset", observed(), 12'h000);
    @(negedge clk);
    press_i = 4'b0000;
    rst = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("post_reset%0d", k), observed(), 12'h000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
